// File: rtl/seg_view_sched.sv
// Display-source scheduler for the 8-digit seven-segment scan display.
// Picks one of four debug words round-robin over valid pages and drives the digit scan.
module seg_view_sched #(
   parameter logic [15:0] SCAN_DIV = 16'd50000,
   parameter logic [31:0] AUTO_DIV = 32'd100_000_000
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] src0,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic [31:0] src3,
   input  logic [3:0]  valid,
   input  logic        next_btn,
   input  logic        auto_en,
   input  logic        freeze,
   output logic [31:0] disp_word,
   output logic [2:0]  digit_sel,
   output logic        scan_tick,
   output logic [1:0]  page,
   output logic [3:0]  page_oh
);

   typedef enum logic [1:0] {
      SHOW   = 2'd0,
      SEARCH = 2'd1,
      FREEZE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  page_q, page_d;
   logic [1:0]  cand_q, cand_d;
   logic [31:0] disp_word_q, disp_word_d;
   logic        btn_q, btn_d;
   logic [15:0] scan_cnt_q, scan_cnt_d;
   logic [2:0]  digit_sel_q, digit_sel_d;
   logic        scan_tick_q, scan_tick_d;
   logic [31:0] auto_cnt_q, auto_cnt_d;

   logic [31:0] page_word;
   logic        btn_req;
   logic        auto_req;
   logic        scan_wrap;
   logic        page_chg;

   always_comb begin
      page_word = src0;
      case (page_q)
         2'd0:    page_word = src0;
         2'd1:    page_word = src1;
         2'd2:    page_word = src2;
         default: page_word = src3;
      endcase
   end

   // Scan path is free-running: it ignores the FSM and freeze entirely.
   always_comb begin
      scan_wrap   = (scan_cnt_q == SCAN_DIV - 16'd1);
      scan_cnt_d  = scan_wrap ? 16'd0 : scan_cnt_q + 16'd1;
      scan_tick_d = scan_wrap;
      digit_sel_d = scan_wrap ? digit_sel_q + 3'd1 : digit_sel_q;
   end

   assign btn_d   = next_btn;
   assign btn_req = next_btn & ~btn_q;

   // A page change only happens out of SEARCH; derived directly to keep the comb paths acyclic.
   assign page_chg = (state_q == SEARCH) && valid[cand_q] && (cand_q != page_q);

   always_comb begin
      auto_req   = 1'b0;
      auto_cnt_d = auto_cnt_q;
      if (!auto_en) begin
         auto_cnt_d = 32'd0;
      end else if (state_q == SHOW && !freeze) begin
         if (auto_cnt_q == AUTO_DIV - 32'd1) begin
            auto_req   = 1'b1;
            auto_cnt_d = 32'd0;
         end else begin
            auto_cnt_d = auto_cnt_q + 32'd1;
         end
      end
      if (page_chg) begin
         auto_cnt_d = 32'd0;
      end
   end

   always_comb begin
      state_d     = state_q;
      page_d      = page_q;
      cand_d      = cand_q;
      disp_word_d = disp_word_q;
      case (state_q)
         SHOW: begin
            disp_word_d = valid[page_q] ? page_word : 32'd0;
            if (freeze) begin
               state_d = FREEZE;
            end else if (btn_req | auto_req) begin
               state_d = SEARCH;
               cand_d  = page_q + 2'd1;
            end
         end
         SEARCH: begin
            // cand == page means every other page was invalid: keep the current one.
            if (valid[cand_q]) begin
               page_d  = cand_q;
               state_d = SHOW;
            end else if (cand_q == page_q) begin
               state_d = SHOW;
            end else begin
               cand_d = cand_q + 2'd1;
            end
         end
         FREEZE: begin
            if (!freeze) begin
               state_d = SHOW;
            end
         end
         default: state_d = SHOW;
      endcase
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= SHOW;
         page_q      <= 2'd0;
         cand_q      <= 2'd0;
         disp_word_q <= 32'd0;
         btn_q       <= 1'b0;
         scan_cnt_q  <= 16'd0;
         digit_sel_q <= 3'd0;
         scan_tick_q <= 1'b0;
         auto_cnt_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         page_q      <= page_d;
         cand_q      <= cand_d;
         disp_word_q <= disp_word_d;
         btn_q       <= btn_d;
         scan_cnt_q  <= scan_cnt_d;
         digit_sel_q <= digit_sel_d;
         scan_tick_q <= scan_tick_d;
         auto_cnt_q  <= auto_cnt_d;
      end
   end

   assign disp_word = disp_word_q;
   assign digit_sel = digit_sel_q;
   assign scan_tick = scan_tick_q;
   assign page      = page_q;
   assign page_oh   = 4'b0001 << page_q;

endmodule

// File: tb/tb_seg_view_sched.sv
// Directed bench for seg_view_sched: stimulus schedules expected samples by cycle number,
// a negedge monitor compares every scheduled sample against the DUT outputs.
module tb_seg_view_sched;

   localparam int F_DISP = 0;
   localparam int F_PAGE = 1;
   localparam int F_OH   = 2;
   localparam int F_DIG  = 3;
   localparam int F_TICK = 4;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic [31:0] src0 = 32'h1234_5678;
   logic [31:0] src1 = 32'hA1A1_0001;
   logic [31:0] src2 = 32'hB2B2_0002;
   logic [31:0] src3 = 32'hC3C3_0003;
   logic [3:0]  valid = 4'b1111;
   logic        next_btn = 1'b0;
   logic        auto_en = 1'b0;
   logic        freeze = 1'b0;
   logic [31:0] disp_word;
   logic [2:0]  digit_sel;
   logic        scan_tick;
   logic [1:0]  page;
   logic [3:0]  page_oh;

   seg_view_sched #(.SCAN_DIV(16'd4), .AUTO_DIV(32'd20)) dut (
      .clk(clk), .clr(clr),
      .src0(src0), .src1(src1), .src2(src2), .src3(src3),
      .valid(valid), .next_btn(next_btn), .auto_en(auto_en), .freeze(freeze),
      .disp_word(disp_word), .digit_sel(digit_sel), .scan_tick(scan_tick),
      .page(page), .page_oh(page_oh)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      int          fld;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t keep_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   rel = 0;

   always @(posedge clk) cyc++;

   function automatic logic [31:0] get_fld(input int f);
      case (f)
         F_DISP:  return disp_word;
         F_PAGE:  return {30'd0, page};
         F_OH:    return {28'd0, page_oh};
         F_DIG:   return {29'd0, digit_sel};
         default: return {31'd0, scan_tick};
      endcase
   endfunction

   function automatic string fname(input int f);
      case (f)
         F_DISP:  return "disp_word";
         F_PAGE:  return "page";
         F_OH:    return "page_oh";
         F_DIG:   return "digit_sel";
         default: return "scan_tick";
      endcase
   endfunction

   // Monitor: compare every expectation scheduled for the current cycle.
   always @(negedge clk) begin
      logic [31:0] act;
      keep_q = {};
      foreach (sb[i]) begin
         if (sb[i].cyc == cyc) begin
            checks++;
            act = get_fld(sb[i].fld);
            if (act !== sb[i].val) begin
               failures++;
               $display("FAIL %s cyc=%0d actual=%h required=%h", fname(sb[i].fld), cyc, act, sb[i].val);
            end
         end else begin
            keep_q.push_back(sb[i]);
         end
      end
      sb = keep_q;
   end

   task automatic expect_at(input int c, input int f, input logic [31:0] v);
      exp_t e;
      e.cyc = c;
      e.fld = f;
      e.val = v;
      sb.push_back(e);
   endtask

   // Scan phase is fixed by the last reset release (rel).
   task automatic expect_scan(input int c);
      int n;
      n = c - rel;
      expect_at(c, F_TICK, (n > 0 && n % 4 == 0) ? 32'd1 : 32'd0);
      expect_at(c, F_DIG, (n / 4) % 8);
   endtask

   task automatic expect_reset_vals(input int c);
      expect_at(c, F_DISP, 32'd0);
      expect_at(c, F_PAGE, 32'd0);
      expect_at(c, F_OH, 32'd1);
      expect_at(c, F_DIG, 32'd0);
      expect_at(c, F_TICK, 32'd0);
   endtask

   function automatic logic [31:0] src_of(input int p);
      case (p)
         0:       return src0;
         1:       return src1;
         2:       return src2;
         default: return src3;
      endcase
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic step_to(input int target);
      while (cyc < target) step(1);
   endtask

   task automatic do_reset();
      clr = 1'b1;
      step(2);
      clr = 1'b0;
      rel = cyc;
   endtask

   task automatic press();
      next_btn = 1'b1;
      step(1);
      next_btn = 1'b0;
   endtask

   initial begin
      int c;
      int g;
      int t0;
      int exp_p;
      int prev_p;

      // Reset state and scan sequence
      step(1);
      expect_reset_vals(cyc);
      checks++;
      if (page_oh !== 4'b0001) begin
         failures++;
         $display("FAIL page_oh in reset actual=%h required=%h", page_oh, 4'b0001);
      end
      checks++;
      if (disp_word !== 32'd0) begin
         failures++;
         $display("FAIL disp_word in reset actual=%h required=%h", disp_word, 32'd0);
      end
      step(1);
      clr = 1'b0;
      rel = cyc;
      expect_at(rel, F_DISP, 32'd0);
      expect_at(rel + 1, F_DISP, 32'h1234_5678);
      expect_at(rel + 1, F_PAGE, 32'd0);
      for (int k = 0; k <= 33; k++) expect_scan(rel + k);
      step(34);

      // Button round-robin, last press held high
      do_reset();
      step(2);
      prev_p = 0;
      for (int i = 0; i < 5; i++) begin
         c = cyc;
         exp_p = (i + 1) % 4;
         expect_at(c + 1, F_PAGE, prev_p);
         expect_at(c + 2, F_PAGE, exp_p);
         expect_at(c + 2, F_OH, 32'd1 << exp_p);
         expect_at(c + 3, F_DISP, src_of(exp_p));
         if (i == 4) begin
            expect_at(c + 10, F_PAGE, exp_p);
            next_btn = 1'b1;
            step(10);
            next_btn = 1'b0;
         end else begin
            press();
         end
         step(4);
         prev_p = exp_p;
      end

      // Skip invalid pages: 3 SEARCH cycles to reach page 3
      valid = 4'b1001;
      do_reset();
      step(2);
      c = cyc;
      expect_at(c + 3, F_PAGE, 32'd0);
      expect_at(c + 4, F_PAGE, 32'd3);
      expect_at(c + 4, F_OH, 32'b1000);
      expect_at(c + 4, F_DISP, 32'h1234_5678);
      expect_at(c + 5, F_DISP, 32'hC3C3_0003);
      press();
      step(6);
      checks++;
      if (page !== 2'd3) begin
         failures++;
         $display("FAIL page after skip actual=%h required=%h", page, 2'd3);
      end
      checks++;
      if (disp_word !== src3) begin
         failures++;
         $display("FAIL disp_word after skip actual=%h required=%h", disp_word, src3);
      end

      // Only page 0 valid: 4 SEARCH cycles, page unchanged
      valid = 4'b0001;
      do_reset();
      step(2);
      c = cyc;
      expect_at(c + 5, F_DISP, 32'h1234_5678);
      expect_at(c + 6, F_DISP, 32'h5555_AAAA);
      expect_at(c + 6, F_PAGE, 32'd0);
      expect_at(c + 8, F_PAGE, 32'd0);
      press();
      src0 = 32'h5555_AAAA;
      step(8);
      checks++;
      if (page !== 2'd0) begin
         failures++;
         $display("FAIL page after full wrap actual=%h required=%h", page, 2'd0);
      end
      src0 = 32'h1234_5678;

      // Auto cycle, with a button edge coinciding with the third expiry
      valid = 4'b1111;
      auto_en = 1'b1;
      do_reset();
      t0 = rel;
      expect_at(t0 + 20, F_PAGE, 32'd0);
      expect_at(t0 + 21, F_PAGE, 32'd1);
      expect_at(t0 + 22, F_DISP, 32'hA1A1_0001);
      expect_at(t0 + 41, F_PAGE, 32'd1);
      expect_at(t0 + 42, F_PAGE, 32'd2);
      expect_at(t0 + 62, F_PAGE, 32'd2);
      expect_at(t0 + 63, F_PAGE, 32'd3);
      expect_at(t0 + 64, F_PAGE, 32'd3);
      expect_at(t0 + 70, F_PAGE, 32'd3);
      step_to(t0 + 61);
      press();
      step_to(t0 + 72);
      auto_en = 1'b0;

      // Freeze holds word and page, discards the request, scan keeps running
      do_reset();
      step(3);
      freeze = 1'b1;
      step(2);
      src0 = 32'hDEAD_BEEF;
      c = cyc;
      for (int k = 0; k <= 6; k++) begin
         expect_at(c + k, F_DISP, 32'h1234_5678);
         expect_at(c + k, F_PAGE, 32'd0);
         expect_scan(c + k);
      end
      press();
      step(6);
      g = cyc;
      freeze = 1'b0;
      expect_at(g + 1, F_DISP, 32'h1234_5678);
      expect_at(g + 2, F_DISP, 32'hDEAD_BEEF);
      expect_at(g + 5, F_PAGE, 32'd0);
      step(6);
      src0 = 32'h1234_5678;

      // Reset asserted in the first SEARCH cycle
      do_reset();
      step(2);
      press();
      step(4);
      press();
      step(4);
      expect_at(cyc, F_PAGE, 32'd2);
      next_btn = 1'b1;
      step(1);
      next_btn = 1'b0;
      clr = 1'b1;
      expect_reset_vals(cyc);
      step(2);
      clr = 1'b0;
      rel = cyc;
      expect_at(rel + 1, F_DISP, 32'h1234_5678);
      expect_at(rel + 3, F_PAGE, 32'd0);
      step(3);
      c = cyc;
      expect_at(c + 2, F_PAGE, 32'd1);
      expect_at(c + 3, F_DISP, 32'hA1A1_0001);
      press();
      step(5);

      // Any expectation never reached is a failure
      foreach (sb[i]) begin
         checks++;
         failures++;
         $display("FAIL unchecked_%s cyc=%0d actual=none required=%h", fname(sb[i].fld), sb[i].cyc, sb[i].val);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
